mul_pipe: RTL

//  Parametrised multi-cycle multiply pipeline for the exec stage, superseding the fixed M1..M5 chain.
//  - Accepts signed operands plus a destination register id.
//  - Returns the low WIDTH bits of the product, zero/overflow flags and dst after STAGES cycles.
//  - Supports stall (hold) and flush (kill in-flight ops).
//  - Exposes in-flight dst hit detection for the hazard unit.

---
 rtl/mul_pipe.sv | 120 ++++++++++++
 1 files changed

// File: rtl/mul_pipe.sv
// Multi-cycle signed multiply pipeline for the exec stage.
// The full product and its flags are formed at issue. Result, flags and dst then ride
// through STAGES register stages, and the last stage drives the outputs.
// Stall holds every stage. Flush clears every valid. Reset clears everything.
module mul_pipe #(
    parameter int unsigned WIDTH  = 32,
    parameter int unsigned STAGES = 5,
    parameter int unsigned DST_W  = 5
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        in_valid,
    input  logic [WIDTH-1:0]            in_a,
    input  logic [WIDTH-1:0]            in_b,
    input  logic [DST_W-1:0]            in_dst,
    input  logic                        stall,
    input  logic                        flush,
    input  logic [DST_W-1:0]            query_dst,
    output logic                        query_hit,
    output logic                        out_valid,
    output logic [WIDTH-1:0]            out_result,
    output logic                        out_zero,
    output logic                        out_overflow,
    output logic [DST_W-1:0]            out_dst,
    output logic [$clog2(STAGES+1)-1:0] in_flight
);

    localparam int unsigned CW = $clog2(STAGES + 1);

    // Per-stage state. Index STAGES-1 is the output stage.
    logic             r_valid  [STAGES];
    logic [WIDTH-1:0] r_result [STAGES];
    logic             r_zero   [STAGES];
    logic             r_ovf    [STAGES];
    logic [DST_W-1:0] r_dst    [STAGES];

    logic signed [2*WIDTH-1:0] w_a_ext;
    logic signed [2*WIDTH-1:0] w_b_ext;
    logic signed [2*WIDTH-1:0] w_prod;
    logic [WIDTH:0]            w_hi;
    logic [WIDTH-1:0]          w_res;
    logic                      w_zero;
    logic                      w_ovf;
    logic [STAGES-1:0]         w_match;
    logic [CW-1:0]             w_cnt [STAGES+1];

    // Full-width signed product. Overflow is set when the bits above the sign bit disagree.
    always_comb begin
        w_a_ext = {{WIDTH{in_a[WIDTH-1]}}, in_a};
        w_b_ext = {{WIDTH{in_b[WIDTH-1]}}, in_b};
        w_prod  = w_a_ext * w_b_ext;
        w_hi    = w_prod[2*WIDTH-1:WIDTH-1];
        w_res   = w_prod[WIDTH-1:0];
        w_zero  = (w_res == '0);
        w_ovf   = (|w_hi) && !(&w_hi);
    end

    // Stage 1 accepts a new op. Data loads only on accept, so an output stage at STAGES=1 holds.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_valid[0]  <= 1'b0;
            r_result[0] <= '0;
            r_zero[0]   <= 1'b0;
            r_ovf[0]    <= 1'b0;
            r_dst[0]    <= '0;
        end else if (flush) begin
            r_valid[0] <= 1'b0;
        end else if (!stall) begin
            r_valid[0] <= in_valid;
            if (in_valid) begin
                r_result[0] <= w_res;
                r_zero[0]   <= w_zero;
                r_ovf[0]    <= w_ovf;
                r_dst[0]    <= in_dst;
            end
        end
    end

    for (genvar k = 1; k < STAGES; k++) begin : g_stage
        localparam bit IsOut = (k == STAGES - 1);

        // Advance stage k-1 into stage k. The output stage loads data only from a valid op.
        always_ff @(posedge clk) begin
            if (reset) begin
                r_valid[k]  <= 1'b0;
                r_result[k] <= '0;
                r_zero[k]   <= 1'b0;
                r_ovf[k]    <= 1'b0;
                r_dst[k]    <= '0;
            end else if (flush) begin
                r_valid[k] <= 1'b0;
            end else if (!stall) begin
                r_valid[k] <= r_valid[k-1];
                if (!IsOut || r_valid[k-1]) begin
                    r_result[k] <= r_result[k-1];
                    r_zero[k]   <= r_zero[k-1];
                    r_ovf[k]    <= r_ovf[k-1];
                    r_dst[k]    <= r_dst[k-1];
                end
            end
        end
    end

    assign w_cnt[0] = '0;

    for (genvar k = 0; k < STAGES; k++) begin : g_scan
        assign w_match[k]  = r_valid[k] && (r_dst[k] == query_dst);
        assign w_cnt[k+1]  = w_cnt[k] + CW'(r_valid[k]);
    end

    // r0 never creates a hazard.
    assign query_hit    = (query_dst != '0) && (|w_match);
    assign in_flight    = w_cnt[STAGES];
    assign out_valid    = r_valid[STAGES-1];
    assign out_result   = r_result[STAGES-1];
    assign out_zero     = r_zero[STAGES-1];
    assign out_overflow = r_ovf[STAGES-1];
    assign out_dst      = r_dst[STAGES-1];

endmodule
